// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
// Glyphs are active-high here; the top level inverts them for the active-low pins.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index = nibble value; bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle of the scan driver: scan source, value to show, and panel drive.
interface seg_scan_if;
  logic        clk_div;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_lead;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (output clk_div, value, dp_en, blank_lead,
                  input  an, seg, dp, frame_done);
  modport slave  (input  clk_div, value, dp_en, blank_lead,
                  output an, seg, dp, frame_done);
endinterface

// File: rtl/seg_scan_hex7seg.sv
// Combinational nibble to active-high seven-segment pattern.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = GLYPH[i_nib];
endmodule

// File: rtl/seg_scan.sv
// Four-digit scan driver: one digit per rising edge of clk_div, anode-off guard before
// each digit change, per-frame snapshot of value/dp_en, optional leading-zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int GUARD = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam logic [3:0] GUARD_LAST = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;

  logic        r_clk_q;
  logic        w_tick;
  state_t      r_state, w_state_next;
  logic [3:0]  r_gcnt, w_gcnt_next;
  logic [1:0]  r_idx, w_idx_next;
  logic [15:0] r_snap, w_snap_next;
  logic [3:0]  r_dp_snap, w_dp_snap_next;
  logic        w_new_frame;
  logic [3:0]  w_blank;
  logic [3:0]  w_nib;
  logic [6:0]  w_glyph;
  logic        w_show;
  logic [3:0]  r_an, w_an_next;
  logic [6:0]  r_seg, w_seg_next;
  logic        r_dp, w_dp_next;
  logic        r_frame_done;

  assign w_tick         = bus.clk_div & ~r_clk_q;
  assign w_idx_next     = w_tick ? r_idx + 2'd1 : r_idx;
  assign w_new_frame    = w_tick && (r_idx == 2'd3);
  assign w_snap_next    = w_new_frame ? bus.value : r_snap;
  assign w_dp_snap_next = w_new_frame ? bus.dp_en : r_dp_snap;

  // Digit k blanks when every nibble from k upward is zero; digit 0 always shows
  assign w_blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_blank
    assign w_blank[gi] = bus.blank_lead && (w_snap_next[15:4*gi] == '0);
  end

  assign w_nib = w_snap_next[4*w_idx_next +: 4];

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gcnt_next  = '0;
    case (r_state)
      IDLE, SHOW: begin
        if (w_tick) w_state_next = (GUARD == 0) ? SHOW : BLANK;
      end
      BLANK: begin
        // A tick here restarts the guard with the count already cleared above
        if (w_tick)                     w_state_next = (GUARD == 0) ? SHOW : BLANK;
        else if (r_gcnt == GUARD_LAST)  w_state_next = SHOW;
        else                            w_gcnt_next  = r_gcnt + 4'd1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are computed from next-cycle state so the registered pins line up with it
  always_comb begin
    w_show     = (w_state_next == SHOW) && !w_blank[w_idx_next];
    w_an_next  = 4'hF;
    w_seg_next = SEG_OFF;
    w_dp_next  = 1'b1;
    if (w_show) begin
      w_an_next  = ~(4'b0001 << w_idx_next);
      w_seg_next = ~w_glyph;
      w_dp_next  = ~w_dp_snap_next[w_idx_next];
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_clk_q      <= 1'b0;
      r_gcnt       <= '0;
      r_idx        <= 2'd3;
      r_snap       <= '0;
      r_dp_snap    <= '0;
      r_an         <= 4'hF;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_clk_q      <= bus.clk_div;
      r_gcnt       <= w_gcnt_next;
      r_idx        <= w_idx_next;
      r_snap       <= w_snap_next;
      r_dp_snap    <= w_dp_snap_next;
      r_an         <= w_an_next;
      r_seg        <= w_seg_next;
      r_dp         <= w_dp_next;
      r_frame_done <= w_new_frame;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: a GUARD=2 instance is checked slot by slot, and a
// GUARD=0 instance on the same inputs is checked one cycle after each tick.
module tb_seg_scan;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 sysclk = ~sysclk;

  seg_scan_if bus ();
  seg_scan_if bus0 ();

  assign bus0.clk_div    = bus.clk_div;
  assign bus0.value      = bus.value;
  assign bus0.dp_en      = bus.dp_en;
  assign bus0.blank_lead = bus.blank_lead;

  seg_scan #(.GUARD(2)) dut  (.sysclk(sysclk), .rst_n(rst_n), .bus(bus.slave));
  seg_scan #(.GUARD(0)) dut0 (.sysclk(sysclk), .rst_n(rst_n), .bus(bus0.slave));

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic        blank_lead;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          fd;
  } vec_t;

  vec_t tbl [12];

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] %-12s ok (%0h)", name, act);
    end
  endtask

  // One scan slot: tick, guard check, glyph check at T+3, frame_done pulse count
  task automatic slot(input string name, input vec_t v);
    int fd;
    bus.value      = v.value;
    bus.dp_en      = v.dp_en;
    bus.blank_lead = v.blank_lead;
    bus.clk_div    = 1'b1;
    cyc();
    fd = int'(bus.frame_done);
    chk({name, "_guard"}, 16'(bus.an), 16'hF);
    chk({name, "_g0an"}, 16'(bus0.an), 16'(v.an));
    chk({name, "_g0seg"}, 16'(bus0.seg), 16'(v.seg));
    bus.clk_div = 1'b0;
    cyc(); fd += int'(bus.frame_done);
    cyc(); fd += int'(bus.frame_done);
    chk({name, "_an"}, 16'(bus.an), 16'(v.an));
    chk({name, "_seg"}, 16'(bus.seg), 16'(v.seg));
    chk({name, "_dp"}, 16'(bus.dp), 16'(v.dp));
    for (int i = 0; i < 3; i++) begin
      cyc(); fd += int'(bus.frame_done);
    end
    chk({name, "_fd"}, 16'(fd), 16'(v.fd));
  endtask

  initial begin
    int fd;
    tbl[0]  = '{16'h12AF, 4'b0100, 1'b0, 4'hE, 7'h0E, 1'b1, 1};
    tbl[1]  = '{16'h12AF, 4'b0100, 1'b0, 4'hD, 7'h08, 1'b1, 0};
    tbl[2]  = '{16'h12AF, 4'b0100, 1'b0, 4'hB, 7'h24, 1'b0, 0};
    tbl[3]  = '{16'h12AF, 4'b0100, 1'b0, 4'h7, 7'h79, 1'b1, 0};
    tbl[4]  = '{16'h0005, 4'b0001, 1'b1, 4'hE, 7'h12, 1'b0, 1};
    tbl[5]  = '{16'h0005, 4'b0001, 1'b1, 4'hF, 7'h7F, 1'b1, 0};
    tbl[6]  = '{16'h0005, 4'b0001, 1'b1, 4'hF, 7'h7F, 1'b1, 0};
    tbl[7]  = '{16'h0005, 4'b0001, 1'b1, 4'hF, 7'h7F, 1'b1, 0};
    tbl[8]  = '{16'h0000, 4'b0000, 1'b1, 4'hE, 7'h40, 1'b1, 1};
    tbl[9]  = '{16'h0000, 4'b0000, 1'b1, 4'hF, 7'h7F, 1'b1, 0};
    tbl[10] = '{16'h0000, 4'b0000, 1'b0, 4'hB, 7'h40, 1'b1, 0};
    tbl[11] = '{16'h0000, 4'b0000, 1'b0, 4'h7, 7'h40, 1'b1, 0};

    bus.clk_div    = 1'b0;
    bus.value      = 16'h0;
    bus.dp_en      = 4'h0;
    bus.blank_lead = 1'b0;

    // Reset held while clk_div toggles
    for (int i = 0; i < 3; i++) begin
      bus.clk_div = (i % 2 == 0);
      cyc();
      chk("rst_an", 16'(bus.an), 16'hF);
      chk("rst_seg", 16'(bus.seg), 16'h7F);
      chk("rst_dp", 16'(bus.dp), 16'h1);
      chk("rst_fd", 16'(bus.frame_done), 16'h0);
    end
    bus.clk_div = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("idle_an", 16'(bus.an), 16'hF);

    // Basic scan, leading-zero blanking, zero value
    for (int i = 0; i < 12; i++) slot($sformatf("vec%0d", i), tbl[i]);

    // Snapshot: value changes while digit 1 is shown
    slot("snap_d0", '{16'h12AF, 4'b0100, 1'b0, 4'hE, 7'h0E, 1'b1, 1});
    slot("snap_d1", '{16'h12AF, 4'b0100, 1'b0, 4'hD, 7'h08, 1'b1, 0});
    bus.value = 16'h3333;
    cyc();
    chk("snap_mid", 16'(bus.seg), 16'h08);
    slot("snap_d2", '{16'h3333, 4'b0100, 1'b0, 4'hB, 7'h24, 1'b0, 0});
    slot("snap_d3", '{16'h3333, 4'b0100, 1'b0, 4'h7, 7'h79, 1'b1, 0});
    slot("snap_n0", '{16'h3333, 4'b0100, 1'b0, 4'hE, 7'h30, 1'b1, 1});

    // clk_div held high: exactly one advance
    bus.clk_div = 1'b1;
    fd = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); fd += int'(bus.frame_done);
    end
    bus.clk_div = 1'b0;
    cyc(); cyc();
    chk("hold_an", 16'(bus.an), 16'hD);
    chk("hold_seg", 16'(bus.seg), 16'h30);
    chk("hold_fd", 16'(fd), 16'h0);
    slot("hold_nx", '{16'h3333, 4'b0100, 1'b0, 4'hB, 7'h30, 1'b0, 0});

    // Reset while digit 2 is lit
    rst_n = 1'b0;
    cyc();
    chk("rmid_an", 16'(bus.an), 16'hF);
    chk("rmid_seg", 16'(bus.seg), 16'h7F);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("rmid_idle", 16'(bus.an), 16'hF);
    slot("rmid_d0", '{16'h3333, 4'b0100, 1'b0, 4'hE, 7'h30, 1'b1, 1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
